// File: rtl/cfg_pkg.sv
// Shared constants and state encoding for the serial configuration loader.
// CFG_LOADER_CRC_EN adds the trailing CRC state.
package cfg_pkg;

    localparam logic [7:0]  CFG_SYNC     = 8'hA5;
    localparam logic [7:0]  CFG_CRC_POLY = 8'h07;
    localparam int unsigned CFG_FRAME_W  = 18;

    typedef enum logic [3:0] {
        StIdle,
        StSync,
        StCount,
        StAddr,
        StData,
        StSetup,
        StStrobe,
        StHold,
`ifdef CFG_LOADER_CRC_EN
        StCrc,
`endif
        StDone,
        StErr
    } cfg_state_e;

endpackage

// File: rtl/cfg_crc8.sv
// Bit-serial CRC-8 (MSB first, init 0) over the loader's payload bits.
// Only built when CFG_LOADER_CRC_EN is defined.
`ifdef CFG_LOADER_CRC_EN
module cfg_crc8
    import cfg_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic       d,
    output logic [7:0] crc
);

    logic [7:0] crc_q, crc_d;
    logic       fb;

    always_comb begin
        fb    = crc_q[7] ^ d;
        crc_d = crc_q;
        if (clr) begin
            crc_d = 8'h00;
        end else if (en) begin
            crc_d = {crc_q[6:0], 1'b0} ^ (fb ? CFG_CRC_POLY : 8'h00);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            crc_q <= 8'h00;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule
`endif

// File: rtl/cfg_loader.sv
// Framed MSB-first serial bitstream to one-hot tile configuration writes.
// CFG_LOADER_CRC_EN appends a CRC-8 check byte after the last frame.
module cfg_loader
    import cfg_pkg::*;
#(
    parameter int unsigned NUM_TILES = 16,
    parameter int unsigned FRAME_W   = CFG_FRAME_W,
    parameter int unsigned ADDR_W    = $clog2(NUM_TILES)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 bs_valid,
    input  logic                 bs_data,
    output logic                 bs_ready,
    output logic [NUM_TILES-1:0] wr_en,
    output logic [FRAME_W-1:0]   bits,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    cfg_state_e          state_q, state_d;
    logic [4:0]          bcnt_q, bcnt_d;
    logic [7:0]          frm_q, frm_d;
    logic [FRAME_W-1:0]  sr_q, sr_d, sr_next;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [FRAME_W-1:0]  bits_q, bits_d;
    logic [4:0]          len_m1;
    logic [31:0]         addr_ext;
    logic                accept, last_bit, idle_like;

`ifdef CFG_LOADER_CRC_EN
    logic [7:0] crc;
    logic       crc_en;

    assign crc_en = accept && (state_q inside {StCount, StAddr, StData});

    cfg_crc8 u_crc (
        .clk (clk),
        .rst (rst),
        .clr (start && idle_like),
        .en  (crc_en),
        .d   (bs_data),
        .crc (crc)
    );
`endif

    always_comb begin
        bs_ready = 1'b0;
        len_m1   = 5'd0;
        unique case (state_q)
            StSync, StCount: begin bs_ready = 1'b1; len_m1 = 5'd7; end
`ifdef CFG_LOADER_CRC_EN
            StCrc:           begin bs_ready = 1'b1; len_m1 = 5'd7; end
`endif
            StAddr:          begin bs_ready = 1'b1; len_m1 = 5'(ADDR_W - 1); end
            StData:          begin bs_ready = 1'b1; len_m1 = 5'(FRAME_W - 1); end
            default:         ;
        endcase
    end

    assign idle_like = (state_q == StIdle) || (state_q == StDone) || (state_q == StErr);
    assign accept    = bs_valid && bs_ready;
    assign last_bit  = accept && (bcnt_q == len_m1);
    assign sr_next   = {sr_q[FRAME_W-2:0], bs_data};
    assign addr_ext  = 32'(sr_next[ADDR_W-1:0]);

    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        frm_d   = frm_q;
        sr_d    = sr_q;
        addr_d  = addr_q;
        bits_d  = bits_q;
        if (accept) begin
            sr_d   = sr_next;
            bcnt_d = last_bit ? 5'd0 : bcnt_q + 5'd1;
        end
        case (state_q)
            StIdle, StDone, StErr: begin
                if (start) begin
                    state_d = StSync;
                    bcnt_d  = 5'd0;
                end
            end
            StSync: if (last_bit) state_d = (sr_next[7:0] == CFG_SYNC) ? StCount : StErr;
            StCount: begin
                if (last_bit) begin
                    if (sr_next[7:0] == 8'h00) begin
                        state_d = StErr;
                    end else begin
                        frm_d   = sr_next[7:0];
                        state_d = StAddr;
                    end
                end
            end
            StAddr: begin
                if (last_bit) begin
                    if (addr_ext >= NUM_TILES) begin
                        state_d = StErr;
                    end else begin
                        addr_d  = sr_next[ADDR_W-1:0];
                        state_d = StData;
                    end
                end
            end
            StData: begin
                // Capture the frame on the way into SETUP so bits is valid there.
                if (last_bit) begin
                    bits_d  = sr_next;
                    state_d = StSetup;
                end
            end
            StSetup:  state_d = StStrobe;
            StStrobe: state_d = StHold;
            StHold: begin
                frm_d = frm_q - 8'd1;
                if (frm_d != 8'd0) begin
                    state_d = StAddr;
                end else begin
`ifdef CFG_LOADER_CRC_EN
                    state_d = StCrc;
`else
                    state_d = StDone;
`endif
                end
            end
`ifdef CFG_LOADER_CRC_EN
            StCrc: if (last_bit) state_d = (sr_next[7:0] == crc) ? StDone : StErr;
`endif
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            bcnt_q  <= 5'd0;
            frm_q   <= 8'd0;
            sr_q    <= '0;
            addr_q  <= '0;
            bits_q  <= '0;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            frm_q   <= frm_d;
            sr_q    <= sr_d;
            addr_q  <= addr_d;
            bits_q  <= bits_d;
        end
    end

    assign wr_en = (state_q == StStrobe) ? ({{(NUM_TILES-1){1'b0}}, 1'b1} << addr_q) : '0;
    assign bits  = bits_q;
    assign busy  = !idle_like;
    assign done  = (state_q == StDone);
    assign err   = (state_q == StErr);

endmodule
